score_scan_ctrl: RTL

- Time-multiplexed scan controller for the pong score display.
- Shares one external 7-segment decoder (4-bit value in, a..g out) between NUM_DIGITS common-cathode digits.
- Sequences decoder input and digit enables, inserts anti-ghosting guard intervals, and suppresses leading zeros.
- Accepts score updates through a shadow register that commits only at frame boundaries, so the display never tears.

---
 rtl/score_scan_if.sv | 32 +++
 rtl/score_scan_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/score_scan_if.sv
// Score scan bus: digit data and display controls in, decoder value and
// digit enables out.
//   digits_in   : packed digit values, digit k at [4k+3:4k]
//   load        : one-cycle strobe capturing digits_in into the shadow register
//   lz_en       : leading-zero suppression enable
//   blank_mask  : per-digit force-dark mask
//   dec_value   : value presented to the shared 7-segment decoder
//   digit_en    : one-hot active-high digit enable, zero when dark
//   pending     : shadow holds a load not yet committed
//   frame_start : first cycle of slot 0
interface score_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    load;
    logic                    lz_en;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [3:0]              dec_value;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    pending;
    logic                    frame_start;

    modport master (
        output digits_in, load, lz_en, blank_mask,
        input  dec_value, digit_en, pending, frame_start
    );

    modport slave (
        input  digits_in, load, lz_en, blank_mask,
        output dec_value, digit_en, pending, frame_start
    );
endinterface

// File: rtl/score_scan_ctrl.sv
// Time-multiplexed scan controller for the pong score display. Drives one
// shared 7-segment decoder and NUM_DIGITS common-cathode digit enables, with
// a blank guard at the start of every slot, leading-zero suppression and a
// shadow register that commits only at the frame boundary.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : score_scan_if slave (see interface for signal list)
module score_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 1024,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    score_scan_if.slave  bus
);

    localparam int unsigned CYC_W  = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;

    localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(DWELL_CYCLES - 1);
    localparam logic [CYC_W-1:0]  CYC_SHOW  = CYC_W'(BLANK_CYCLES);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [DATA_W-1:0]     active_q, active_d;
    logic [DATA_W-1:0]     shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic                  frame_q, frame_d;
    logic [3:0]            dec_value_q, dec_value_d;
    logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;

    logic                  frame_end;
    logic [3:0]            cur_digit;
    logic                  masked;
    logic                  upper_zero;
    logic                  dark;

    // State and output registers.
    // frame_q resets to 1 so frame_start rises as soon as reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q       <= '0;
            slot_q      <= '0;
            active_q    <= '0;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            frame_q     <= 1'b1;
            dec_value_q <= '0;
            digit_en_q  <= '0;
        end else begin
            cyc_q       <= cyc_d;
            slot_q      <= slot_d;
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            frame_q     <= frame_d;
            dec_value_q <= dec_value_d;
            digit_en_q  <= digit_en_d;
        end
    end

    // Next state; outputs are computed from the next (slot, cyc, active) so
    // the registered outputs line up with the cycle they describe.
    always_comb begin
        cyc_d       = cyc_q + CYC_W'(1);
        slot_d      = slot_q;
        active_d    = active_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        cur_digit   = 4'd0;
        masked      = 1'b0;
        upper_zero  = 1'b1;
        dark        = 1'b0;
        digit_en_d  = '0;

        if (cyc_q == CYC_LAST) begin
            cyc_d  = '0;
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
        end

        // Commit edge: a load on this very edge bypasses the shadow.
        frame_end = (slot_q == SLOT_LAST) && (cyc_q == CYC_LAST);
        if (frame_end) begin
            if (bus.load) begin
                active_d = bus.digits_in;
            end else if (pending_q) begin
                active_d = shadow_q;
            end
            pending_d = 1'b0;
        end else if (bus.load) begin
            pending_d = 1'b1;
        end

        if (bus.load) begin
            shadow_d = bus.digits_in;
        end

        // Current digit, its mask bit, and whether it and every higher digit are zero.
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (SLOT_W'(k) == slot_d) begin
                cur_digit = active_d[4*k +: 4];
                masked    = bus.blank_mask[k];
            end
            if ((SLOT_W'(k) >= slot_d) && (active_d[4*k +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end

        // Values above 9 have no glyph in the decoder, so they stay dark.
        dark = masked || (cur_digit > 4'd9) ||
               (bus.lz_en && (slot_d != '0) && upper_zero);

        if ((cyc_d >= CYC_SHOW) && !dark) begin
            digit_en_d = NUM_DIGITS'(1) << slot_d;
        end

        dec_value_d = cur_digit;
        frame_d     = (slot_d == '0) && (cyc_d == '0);
    end

    assign bus.dec_value   = dec_value_q;
    assign bus.digit_en    = digit_en_q;
    assign bus.pending     = pending_q;
    assign bus.frame_start = frame_q & ~reset;

endmodule
